// File: rtl/xy_point_receiver.sv
// XY point receiver: collects 16-bit point words from a host over a 3-wire serial link
// into a small buffer and replays the committed points as X/Y DAC codes with a frame trigger.
module xy_point_receiver #(
    parameter int DEPTH       = 16,
    parameter int DWELL       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_sck,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic [7:0]               BNC_x,
    output logic [6:0]               BNC_y,
    output logic                     BNC_trig,
    output logic [$clog2(DEPTH):0]   point_count,
    output logic                     rx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    logic [3:0]             r_bit_cnt;
    logic [15:0]            r_shift;
    logic                   r_wr_pending;
    logic [AW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;

    logic [14:0]            r_mem [DEPTH];

    state_t                 r_state;
    logic [AW-1:0]          r_play_idx;
    logic [DW-1:0]          r_dwell;
    logic                   r_load;
    logic [7:0]             r_x;
    logic [6:0]             r_y;
    logic                   r_trig;

    logic                   w_sck;
    logic                   w_cs_n;
    logic                   w_mosi;
    logic                   w_sck_rise;
    logic                   w_cs_fall;
    logic [CW-1:0]          w_idx_inc;
    logic [AW-1:0]          w_next_idx;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_cs_fall  = ~w_cs_n & r_cs_prev;

    // cs_n chain resets to its idle (deselected) level so rx_busy reads 0 out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_wr_pending <= 1'b0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_wr_pending <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[14:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd15)
                    r_wr_pending <= 1'b1;
            end
            // The completed word sits in r_shift for this cycle; commit bookkeeping follows the write.
            if (r_wr_pending) begin
                if (r_shift[15]) begin
                    r_count  <= {1'b0, r_wr_ptr} + CW'(1);
                    r_wr_ptr <= '0;
                end else if (r_wr_ptr == AW'(DEPTH - 1)) begin
                    r_count  <= CW'(DEPTH);
                    r_wr_ptr <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end
            if (w_cs_fall)
                r_wr_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_wr_pending)
            r_mem[r_wr_ptr] <= r_shift[14:0];
    end

    assign w_idx_inc  = {1'b0, r_play_idx} + CW'(1);
    assign w_next_idx = (w_idx_inc >= r_count) ? '0 : r_play_idx + AW'(1);

    // Outputs reload only at the start of each dwell, so a write to the shown entry
    // becomes visible from the next dwell onward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_play_idx <= '0;
            r_dwell    <= '0;
            r_load     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (r_load) begin
                r_x    <= r_mem[r_play_idx][7:0];
                r_y    <= r_mem[r_play_idx][14:8];
                r_trig <= (r_play_idx == '0);
            end
            case (r_state)
                S_IDLE: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_trig <= 1'b0;
                    if (r_count != '0) begin
                        r_state    <= S_PLAY;
                        r_play_idx <= '0;
                        r_dwell    <= '0;
                        r_load     <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                    end else if (r_dwell == DW'(DWELL - 1)) begin
                        r_dwell    <= '0;
                        r_play_idx <= w_next_idx;
                        r_load     <= 1'b1;
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BNC_x       = r_x;
    assign BNC_y       = r_y;
    assign BNC_trig    = r_trig;
    assign point_count = r_count;
    assign rx_busy     = ~w_cs_n;

endmodule

// File: tb/tb_xy_point_receiver.sv
// Self-checking bench for xy_point_receiver: drives the serial host side and checks
// point_count and the replayed X/Y/trig stream against a buffer model and fixed tables.
module tb_xy_point_receiver;
    localparam int DEPTH = 16;
    localparam int DWELL = 4;
    localparam int SS    = 2;
    localparam int HALF  = 4;
    localparam int BUDGET = DEPTH * DWELL * 2 + 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] bx;
    logic [6:0] by;
    logic       bt;
    logic [4:0] pc;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] m_mem [DEPTH];
    int          m_count = 0;
    int          m_wr = 0;
    logic [15:0] tx [32];

    typedef struct {
        logic [15:0] word;
        logic [7:0]  x;
        logic [6:0]  y;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    xy_point_receiver #(.DEPTH(DEPTH), .DWELL(DWELL), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .BNC_x(bx), .BNC_y(by), .BNC_trig(bt), .point_count(pc), .rx_busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Buffer model: write at the write pointer, then apply the commit rules.
    task automatic model_word(input logic [15:0] w);
        m_mem[m_wr] = w[14:0];
        if (w[15]) begin
            m_count = m_wr + 1;
            m_wr = 0;
        end else if (m_wr == DEPTH - 1) begin
            m_count = DEPTH;
            m_wr = 0;
        end else begin
            m_wr++;
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input int nb);
        for (int i = 15; i >= 16 - nb; i--) begin
            sck = 1'b0;
            mosi = w[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input int n);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        chk("rx_busy_in_frame", int'(busy), 1);
        m_wr = 0;
        for (int k = 0; k < n; k++) begin
            send_bits(tx[k], 16);
            model_word(tx[k]);
        end
        cs_n = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        chk("rx_busy_idle", int'(busy), 0);
        chk("point_count", int'(pc), m_count);
    endtask

    // From the current sample onward, expect ncyc cycles of the model playback starting at entry 0.
    task automatic check_seq(input string name, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int idx;
            idx = (c / DWELL) % m_count;
            chk({name, "_x"}, int'(bx), int'(m_mem[idx][7:0]));
            chk({name, "_y"}, int'(by), int'(m_mem[idx][14:8]));
            chk({name, "_trig"}, int'(bt), (idx == 0) ? 1 : 0);
            @(negedge clk);
        end
    endtask

    task automatic check_play(input string name);
        int t;
        if (m_count == 0) return;
        t = 0;
        while (bt !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
        if (bt !== 1'b1) begin timeout({name, "_trig_high"}); return; end
        if (m_count > 1) begin
            t = 0;
            while (bt !== 1'b0 && t < BUDGET) begin @(negedge clk); t++; end
            if (bt !== 1'b0) begin timeout({name, "_trig_low"}); return; end
            t = 0;
            while (bt !== 1'b1 && t < BUDGET) begin @(negedge clk); t++; end
            if (bt !== 1'b1) begin timeout({name, "_trig_rise"}); return; end
        end
        check_seq(name, m_count * DWELL);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [15:0] w;
        logic [7:0] x_at_commit;

        vecs[0] = '{word: 16'h8001, x: 8'd1,    y: 7'd0};
        vecs[1] = '{word: 16'h80FF, x: 8'd255,  y: 7'd0};
        vecs[2] = '{word: 16'hFF00, x: 8'd0,    y: 7'd127};
        vecs[3] = '{word: 16'hD5AA, x: 8'hAA,   y: 7'h55};

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_x", int'(bx), 0);
        chk("rst_y", int'(by), 0);
        chk("rst_trig", int'(bt), 0);
        chk("rst_count", int'(pc), 0);
        chk("rst_busy", int'(busy), 0);

        // Three-point frame.
        tx[0] = 16'h0096; tx[1] = 16'h7EC5; tx[2] = 16'h8A03;
        send_frame(3);
        chk("three_count", int'(pc), 3);
        check_play("three");

        // 17 words without eol: wraps, entry 0 ends up with x=16.
        for (int k = 0; k < 17; k++) tx[k] = 16'(k);
        send_frame(17);
        chk("wrap_count", int'(pc), 16);
        check_play("wrap");

        // Single-point table.
        for (int v = 0; v < 4; v++) begin
            tx[0] = vecs[v].word;
            send_frame(1);
            chk("vec_count", int'(pc), 1);
            for (int c = 0; c < 2 * DWELL; c++) begin
                chk("vec_x", int'(bx), int'(vecs[v].x));
                chk("vec_y", int'(by), int'(vecs[v].y));
                chk("vec_trig", int'(bt), 1);
                @(negedge clk);
            end
        end

        // Partial word aborted after 9 bits, then a one-word frame.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(16'hFFFF, 9);
        cs_n = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        tx[0] = 16'h8001;
        send_frame(1);
        chk("partial_count", int'(pc), 1);
        for (int c = 0; c < 3 * DWELL; c++) begin
            chk("partial_x", int'(bx), 1);
            chk("partial_y", int'(by), 0);
            chk("partial_trig", int'(bt), 1);
            @(negedge clk);
        end

        // Eight points, then a three-point commit landing while index 6 is shown.
        for (int k = 0; k < 8; k++) tx[k] = {(k == 7) ? 1'b1 : 1'b0, 7'(k), 8'(100 + k)};
        send_frame(8);
        check_play("eight");
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        m_wr = 0;
        for (int k = 0; k < 2; k++) begin
            w = {1'b0, 7'(50 + k), 8'(200 + k)};
            send_bits(w, 16);
            model_word(w);
        end
        w = {1'b1, 7'd52, 8'd202};
        send_bits(w, 15);
        mosi = w[0];
        t = 0;
        while (bx !== 8'd105 && t < BUDGET) begin @(negedge clk); t++; end
        if (bx !== 8'd105) timeout("late_wait_idx5");
        sck = 1'b1;
        model_word(w);
        t = 0;
        while (pc !== 5'd3 && t < 20) begin @(negedge clk); t++; end
        if (pc !== 5'd3) timeout("late_commit");
        x_at_commit = bx;
        chk("late_shown_at_commit", int'(x_at_commit), 106);
        t = 0;
        while (bx === x_at_commit && t < DWELL + 2) begin @(negedge clk); t++; end
        chk("late_next_x", int'(bx), 200);
        chk("late_next_trig", int'(bt), 1);
        check_seq("late", 2 * 3 * DWELL);
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF + 4) @(negedge clk);

        // Reset pulse mid-word and mid-playback.
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(16'h1234, 5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_x", int'(bx), 0);
        chk("midrst_y", int'(by), 0);
        chk("midrst_trig", int'(bt), 0);
        chk("midrst_count", int'(pc), 0);
        chk("midrst_busy", int'(busy), 0);
        m_count = 0;
        m_wr = 0;
        cs_n = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        tx[0] = 16'h0011; tx[1] = 16'h2233; tx[2] = 16'hC455;
        send_frame(3);
        check_play("after_rst");

        // Randomized frames against the buffer model.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) begin
                w = 16'($urandom);
                if (k == n - 1) w[15] = ($urandom_range(0, 3) != 0);
                else            w[15] = ($urandom_range(0, 7) == 0);
                tx[k] = w;
            end
            send_frame(n);
            check_play("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
